// File: rtl/phys_free_list_pkg.sv
// Shared sizing, tag type and pointer helpers for the physical-register free list.
package phys_free_list_pkg;

   localparam int NUM_PHYS = 256;
   localparam int NUM_ARCH = 32;
   localparam int PTAG_W   = $clog2(NUM_PHYS);
   localparam int DEPTH    = NUM_PHYS - NUM_ARCH;
   localparam int CNT_W    = 8;

   localparam logic [CNT_W:0] DEPTH_X = (CNT_W+1)'(DEPTH);

   typedef logic [PTAG_W-1:0] ptag_t;

   function automatic logic [2:0] popcount4(input logic [3:0] m);
      return {2'b0, m[0]} + {2'b0, m[1]} + {2'b0, m[2]} + {2'b0, m[3]};
   endfunction

   // DEPTH is not a power of two, so the wrap is an explicit compare-and-subtract.
   function automatic logic [CNT_W-1:0] wrap_add(input logic [CNT_W-1:0] ptr,
                                                 input logic [2:0]       k);
      logic [CNT_W:0] s;
      s = {1'b0, ptr} + {{(CNT_W-2){1'b0}}, k};
      if (s >= DEPTH_X) s = s - DEPTH_X;
      return s[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/phys_free_list_if.sv
// Rename-side allocate and commit-side release bundle of the free list.
// master = rename/commit logic, slave = free list.
interface phys_free_list_if;
   import phys_free_list_pkg::*;

   logic [3:0]       alloc_req;
   logic             alloc_ok;
   ptag_t            alloc_tag0;
   ptag_t            alloc_tag1;
   ptag_t            alloc_tag2;
   ptag_t            alloc_tag3;
   logic [3:0]       free_valid;
   ptag_t            free_tag0;
   ptag_t            free_tag1;
   ptag_t            free_tag2;
   ptag_t            free_tag3;
   logic [CNT_W-1:0] free_count;
   logic             err_overflow;
   logic             err_underflow;

   modport master (
      output alloc_req, free_valid, free_tag0, free_tag1, free_tag2, free_tag3,
      input  alloc_ok, alloc_tag0, alloc_tag1, alloc_tag2, alloc_tag3,
             free_count, err_overflow, err_underflow
   );

   modport slave (
      input  alloc_req, free_valid, free_tag0, free_tag1, free_tag2, free_tag3,
      output alloc_ok, alloc_tag0, alloc_tag1, alloc_tag2, alloc_tag3,
             free_count, err_overflow, err_underflow
   );

endinterface

// File: rtl/phys_free_list_lane_compact.sv
// Maps a 4-lane mask to each lane's slot offset (count of set lanes below it).
// Purely combinational; no flow control.
module phys_free_list_lane_compact (
   input  logic [3:0]      mask_i,
   output logic [3:0][1:0] off_o
);

   always_comb begin
      off_o[0] = 2'd0;
      off_o[1] = {1'b0, mask_i[0]};
      off_o[2] = {1'b0, mask_i[0]} + {1'b0, mask_i[1]};
      off_o[3] = {1'b0, mask_i[0]} + {1'b0, mask_i[1]} + {1'b0, mask_i[2]};
   end

endmodule

// File: rtl/phys_free_list.sv
// Circular free list of physical tags: 4-wide all-or-nothing alloc, 4-wide release.
// Tags are zero-latency from head; a short list stalls rename via alloc_ok, excess releases drop.
module phys_free_list
   import phys_free_list_pkg::*;
(
   input logic             clk,
   input logic             reset,
   phys_free_list_if.slave bus
);

   ptag_t            q_q [DEPTH];
   logic [CNT_W-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
   logic             err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;

   logic [3:0]       req, fv;
   ptag_t            free_tag  [4];
   ptag_t            alloc_tag [4];
   logic [3:0][1:0]  a_off, f_off;
   logic [CNT_W-1:0] rd_idx [4];
   logic [CNT_W-1:0] wr_idx [4];
   logic [CNT_W-1:0] n_alloc, n_free, alloc_amt, post_alloc;
   logic [CNT_W:0]   post_free;
   logic             alloc_ok, fire, drop;

   assign req         = bus.alloc_req;
   assign fv          = bus.free_valid;
   assign free_tag[0] = bus.free_tag0;
   assign free_tag[1] = bus.free_tag1;
   assign free_tag[2] = bus.free_tag2;
   assign free_tag[3] = bus.free_tag3;

   phys_free_list_lane_compact u_alloc_compact (.mask_i(req), .off_o(a_off));
   phys_free_list_lane_compact u_free_compact  (.mask_i(fv),  .off_o(f_off));

   always_comb begin
      n_alloc    = {{(CNT_W-3){1'b0}}, popcount4(req)};
      n_free     = {{(CNT_W-3){1'b0}}, popcount4(fv)};
      alloc_ok   = (count_q >= n_alloc);
      fire       = alloc_ok && (|req);
      alloc_amt  = fire ? n_alloc : '0;
      post_alloc = count_q - alloc_amt;
      post_free  = {1'b0, post_alloc} + {1'b0, n_free};
      // Releases are judged against the count after this cycle's allocation.
      drop       = (|fv) && (post_free > DEPTH_X);

      count_d   = drop ? post_alloc : post_free[CNT_W-1:0];
      head_d    = fire ? wrap_add(head_q, popcount4(req)) : head_q;
      tail_d    = ((|fv) && !drop) ? wrap_add(tail_q, popcount4(fv)) : tail_q;
      err_ovf_d = err_ovf_q | drop;
      err_udf_d = err_udf_q | ((|req) & ~alloc_ok);

      for (int i = 0; i < 4; i++) begin
         rd_idx[i]    = wrap_add(head_q, {1'b0, a_off[i]});
         wr_idx[i]    = wrap_add(tail_q, {1'b0, f_off[i]});
         alloc_tag[i] = req[i] ? q_q[rd_idx[i]] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) q_q[i] <= ptag_t'(NUM_ARCH + i);
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= CNT_W'(DEPTH);
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (fv[i] && !drop) q_q[wr_idx[i]] <= free_tag[i];
         end
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         err_ovf_q <= err_ovf_d;
         err_udf_q <= err_udf_d;
      end
   end

   assign bus.alloc_ok      = alloc_ok;
   assign bus.alloc_tag0    = alloc_tag[0];
   assign bus.alloc_tag1    = alloc_tag[1];
   assign bus.alloc_tag2    = alloc_tag[2];
   assign bus.alloc_tag3    = alloc_tag[3];
   assign bus.free_count    = count_q;
   assign bus.err_overflow  = err_ovf_q;
   assign bus.err_underflow = err_udf_q;

endmodule

// File: tb/tb_phys_free_list.sv
// Scoreboard bench for phys_free_list: a tag-queue model predicts grants, counts and flags.
module tb_phys_free_list;
   import phys_free_list_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   phys_free_list_if u_if ();

   phys_free_list dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   int checks   = 0;
   int failures = 0;
   int model [$];
   int exp_q [$];
   bit exp_ov, exp_uf;
   logic [31:0] obs_tag [4];

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] get_tag(input int i);
      case (i)
         0:       return 32'(u_if.alloc_tag0);
         1:       return 32'(u_if.alloc_tag1);
         2:       return 32'(u_if.alloc_tag2);
         default: return 32'(u_if.alloc_tag3);
      endcase
   endfunction

   task automatic drive(input logic [3:0] req, input logic [3:0] fv,
                        input int f0, input int f1, input int f2, input int f3);
      u_if.alloc_req  = req;
      u_if.free_valid = fv;
      u_if.free_tag0  = ptag_t'(f0);
      u_if.free_tag1  = ptag_t'(f1);
      u_if.free_tag2  = ptag_t'(f2);
      u_if.free_tag3  = ptag_t'(f3);
   endtask

   task automatic model_reset();
      model.delete();
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) model.push_back(NUM_ARCH + i);
      exp_ov = 1'b0;
      exp_uf = 1'b0;
   endtask

   // Inputs given here are held during reset and zeroed on release.
   task automatic do_reset(input int cycles, input logic [3:0] req, input logic [3:0] fv);
      @(negedge clk);
      reset = 1'b0;
      drive(req, fv, 1, 2, 3, 4);
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      drive(4'b0000, 4'b0000, 0, 0, 0, 0);
      model_reset();
      #1;
      chk("rst_free_count", 32'(u_if.free_count), 224);
      chk("rst_alloc_ok",   32'(u_if.alloc_ok), 1);
      chk("rst_err_ovf",    32'(u_if.err_overflow), 0);
      chk("rst_err_udf",    32'(u_if.err_underflow), 0);
   endtask

   task automatic step(input logic [3:0] req, input logic [3:0] fv,
                       input int f0 = 0, input int f1 = 0, input int f2 = 0, input int f3 = 0);
      int ft [4];
      int n, nf;
      bit ok;
      ft[0] = f0; ft[1] = f1; ft[2] = f2; ft[3] = f3;
      @(negedge clk);
      drive(req, fv, f0, f1, f2, f3);
      #1;
      n  = $countones(req);
      nf = $countones(fv);
      ok = (model.size() >= n);
      chk("alloc_ok", 32'(u_if.alloc_ok), int'(ok));
      for (int i = 0; i < 4; i++) obs_tag[i] = get_tag(i);
      if (ok) begin
         for (int i = 0; i < 4; i++) exp_q.push_back(req[i] ? model.pop_front() : 0);
         for (int i = 0; i < 4; i++) chk($sformatf("alloc_tag%0d", i), obs_tag[i], exp_q.pop_front());
      end else if (n > 0) begin
         exp_uf = 1'b1;
      end
      if (nf > 0) begin
         if (model.size() + nf > DEPTH) exp_ov = 1'b1;
         else for (int i = 0; i < 4; i++) if (fv[i]) model.push_back(ft[i]);
      end
      @(posedge clk);
      #1;
      chk("free_count",    32'(u_if.free_count), model.size());
      chk("err_overflow",  32'(u_if.err_overflow), int'(exp_ov));
      chk("err_underflow", 32'(u_if.err_underflow), int'(exp_uf));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      drive(4'b0000, 4'b0000, 0, 0, 0, 0);
      do_reset(2, 4'b0000, 4'b0000);

      step(4'b1111, 4'b0000);
      chk("first_tag0", obs_tag[0], 32);
      chk("first_tag3", obs_tag[3], 35);
      step(4'b1111, 4'b0000);
      chk("second_tag0", obs_tag[0], 36);
      chk("second_tag3", obs_tag[3], 39);

      do_reset(1, 4'b0000, 4'b0000);
      step(4'b0101, 4'b0000);
      chk("sparse_tag0", obs_tag[0], 32);
      chk("sparse_tag1", obs_tag[1], 0);
      chk("sparse_tag2", obs_tag[2], 33);
      chk("sparse_tag3", obs_tag[3], 0);
      chk("sparse_count", 32'(u_if.free_count), 222);

      do_reset(1, 4'b0000, 4'b0000);
      repeat (56) step(4'b1111, 4'b0000);
      chk("empty_count", 32'(u_if.free_count), 0);
      step(4'b0001, 4'b0000);
      chk("empty_udf", 32'(u_if.err_underflow), 1);
      step(4'b0000, 4'b0011, 5, 9);
      chk("refill_count", 32'(u_if.free_count), 2);
      step(4'b0011, 4'b0000);
      chk("refill_tag0", obs_tag[0], 5);
      chk("refill_tag1", obs_tag[1], 9);

      step(4'b0000, 4'b1111, 10, 11, 12, 13);
      step(4'b1111, 4'b1111, 200, 201, 202, 203);
      chk("simul_tag0", obs_tag[0], 10);
      chk("simul_tag3", obs_tag[3], 13);
      chk("simul_count", 32'(u_if.free_count), 4);
      step(4'b1111, 4'b0000);
      chk("simul_next0", obs_tag[0], 200);
      chk("simul_next3", obs_tag[3], 203);

      do_reset(1, 4'b0000, 4'b0000);
      repeat (55) step(4'b1111, 4'b0000);
      step(4'b0011, 4'b0000);
      step(4'b0000, 4'b1111, 100, 101, 102, 103);
      step(4'b1111, 4'b0000);
      chk("wrap_tag0", obs_tag[0], 254);
      chk("wrap_tag1", obs_tag[1], 255);
      chk("wrap_tag2", obs_tag[2], 100);
      chk("wrap_tag3", obs_tag[3], 101);
      step(4'b0011, 4'b0000);
      chk("wrap_head0", obs_tag[0], 102);
      chk("wrap_head1", obs_tag[1], 103);

      do_reset(1, 4'b0000, 4'b0000);
      step(4'b0000, 4'b0001, 7);
      chk("ovf_flag",  32'(u_if.err_overflow), 1);
      chk("ovf_count", 32'(u_if.free_count), 224);
      step(4'b0001, 4'b1111, 1, 2, 3, 4);
      chk("ovf_alloc_tag", obs_tag[0], 32);
      chk("ovf_alloc_count", 32'(u_if.free_count), 223);

      step(4'b1111, 4'b0000);
      step(4'b0011, 4'b0000);
      do_reset(1, 4'b1111, 4'b1111);
      step(4'b0001, 4'b0000);
      chk("post_rst_tag", obs_tag[0], 32);

      @(negedge clk);
      drive(4'b0000, 4'b0000, 0, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/phys_free_list.md
Name: phys_free_list

Overview:
- Physical-register free list feeding the 4-wide rename/dispatch stage, which sits directly upstream of the reorder buffer.
- Hands out up to 4 free physical tags per cycle for new destinations.
- Takes back up to 4 tags per cycle from retirement: the previous physical mapping of each committed destination.
- Implemented as a circular buffer of tags with all-or-nothing 4-wide allocation and independent 4-wide release.

Parameters:
- NUM_PHYS, 256, total physical registers.
- NUM_ARCH, 32, architectural registers; tags 0..NUM_ARCH-1 are mapped at reset and are not free.
- PTAG_W, 8, physical tag width, log2(NUM_PHYS).
- DEPTH, NUM_PHYS-NUM_ARCH (224), buffer entries.
- CNT_W, 8, counter/pointer width, must hold DEPTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- alloc_req  in  4  lane i of the rename group needs a destination tag
- alloc_ok  out  1  enough free tags exist for every requesting lane
- alloc_tag0..alloc_tag3  out  PTAG_W each  tag granted to lane 0..3
- free_valid  in  4  lane i of the commit group releases a tag
- free_tag0..free_tag3  in  PTAG_W each  tag released by lane 0..3
- free_count  out  CNT_W  number of tags currently in the buffer
- err_overflow  out  1  sticky: a release would exceed DEPTH
- err_underflow  out  1  sticky: an allocation was attempted while alloc_ok=0

Behaviour:
- Reset (reset=0 at posedge):
  - Q[i] <= NUM_ARCH+i for i in 0..DEPTH-1.
  - head <= 0, tail <= 0, count <= DEPTH.
  - err_overflow <= 0, err_underflow <= 0.
  - After reset: free_count=224, alloc_ok=1.
  - Reset asserted mid-operation discards all in-flight state the same way; no partial state survives.
- n_alloc = popcount(alloc_req); n_free = popcount(free_valid). Both are 3-bit, zero-extended to CNT_W.
- alloc_ok (combinational) = (count >= n_alloc). With alloc_req=0, alloc_ok=1.
- Tag compaction: requesting lanes receive Q[head], Q[head+1], ... in ascending lane order.
  - Example: alloc_req=4'b1010 gives alloc_tag1=Q[head], alloc_tag3=Q[head+1].
  - alloc_tag of a non-requesting lane = 0.
  - Tags are combinational from head: zero-cycle latency, same cycle as alloc_req.
- Allocate fires when alloc_ok=1 and n_alloc>0: head <= (head+n_alloc) mod DEPTH.
- Allocation is all-or-nothing. If alloc_ok=0 with n_alloc>0: no tags are consumed, head holds, err_underflow <= 1. Rename must stall and re-present the same alloc_req.
- Release of valid lanes:
  - Tags are written in ascending lane order to Q[tail], Q[tail+1], ...
  - tail <= (tail+n_free) mod DEPTH.
  - Released tags become allocatable the next cycle, not the same cycle.
- Overflow: if count - (fired ? n_alloc : 0) + n_free > DEPTH, all releases that cycle are dropped (no writes, tail holds) and err_overflow <= 1. Allocation in that cycle still proceeds.
- Count update: count <= count - (fired ? n_alloc : 0) + (dropped ? 0 : n_free). Simultaneous alloc and free in one cycle are legal.
- Wrap-around:
  - DEPTH is not a power of two, so every pointer add uses explicit modulo: if sum >= DEPTH, subtract DEPTH.
  - Applies to the head+k read offsets and the tail+k write offsets, k in 0..3.
- Empty: count=0 gives alloc_ok=0 for any nonzero alloc_req.
- Full: count=DEPTH gives head==tail. count, not pointer equality, is authoritative.
- free_count = count (registered). Error flags clear only on reset.

Decomposition:
- rename_pkg holds:
  - PTAG_W, NUM_PHYS, NUM_ARCH, DEPTH localparams;
  - typedef ptag_t (logic [PTAG_W-1:0]);
  - function popcount4;
  - function wrap_add (ptr + k mod DEPTH).
- Sub-module lane_compact: maps a 4-bit request mask to per-lane offsets 0..3. Reused for both the alloc and free lane ordering.

Test Plan:
- Reset, then alloc_req=4'b1111 -> alloc_ok=1, tags 32,33,34,35; next cycle free_count=220 and tags 36..39.
- From reset, alloc_req=4'b0101 -> alloc_tag0=32, alloc_tag2=33, alloc_tag1=alloc_tag3=0; free_count=222.
- Allocate 56 cycles x4 (count 0) -> alloc_ok=0 for alloc_req=4'b0001, head unchanged, err_underflow=1.
- Then free_valid=4'b0011 with tags 5,9 -> next cycle free_count=2. alloc_req=4'b0011 -> tags 5,9.
- Same-cycle alloc of 4 and free of 4 (tags 200..203) at count=4 -> free_count stays 4. Freed tags are not returned until the buffer order reaches them.
- Wrap: drive head to 222, then alloc 4 -> tags Q[222],Q[223],Q[0],Q[1]; head=2.
- At count=224, free_valid=4'b0001 -> release dropped, err_overflow=1, free_count=224.
- Reset asserted mid-stream -> next cycle free_count=224, errors cleared, first alloc returns 32.
